// File: rtl/mby_gmm_msh_pkg.sv
// Shared types and default constants for the GMM mesh request scheduler.
package mby_gmm_msh_pkg;

   localparam int unsigned DEF_NUM_REQ  = 4;
   localparam int unsigned DEF_ADDR_W   = 20;
   localparam int unsigned DEF_CRED_MAX = 8;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_DRAIN   = 2'd1,
      ST_DRAINED = 2'd2
   } sched_state_e;

   typedef struct packed {
      logic                  wr;
      logic [DEF_ADDR_W-1:0] addr;
   } msh_req_t;

endpackage

// File: rtl/mby_gmm_rr_arb.sv
// Round-robin picker: first asserted request at or after the pointer, wrapping.
module mby_gmm_rr_arb
   import mby_gmm_msh_pkg::*;
#(
   parameter int unsigned NUM_REQ = DEF_NUM_REQ
) (
   input  logic [NUM_REQ-1:0]         i_req,
   input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
   input  logic                       i_en,
   output logic [NUM_REQ-1:0]         o_gnt_c,
   output logic [$clog2(NUM_REQ)-1:0] o_idx_c
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   logic        w_found;
   int unsigned w_j;

   always_comb begin
      o_gnt_c = '0;
      o_idx_c = '0;
      w_found = 1'b0;
      w_j     = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         w_j = (32'(i_ptr) + k) % NUM_REQ;
         if (i_en && !w_found && i_req[IDX_W'(w_j)]) begin
            o_gnt_c[IDX_W'(w_j)] = 1'b1;
            o_idx_c              = IDX_W'(w_j);
            w_found              = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mby_gmm_msh_req_sched.sv
// Credit-based round-robin scheduler of requester traffic onto the mesh,
// with a drain handshake that waits for all credits to return.
module mby_gmm_msh_req_sched
   import mby_gmm_msh_pkg::*;
#(
   parameter int unsigned NUM_REQ  = DEF_NUM_REQ,
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter int unsigned CRED_MAX = DEF_CRED_MAX
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_wr,
   input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          msh_valid,
   output logic                          msh_wr,
   output logic [ADDR_W-1:0]             msh_addr,
   output logic [$clog2(NUM_REQ)-1:0]    msh_src,
   input  logic                          msh_cred_ret,
   input  logic                          drain_req,
   output logic                          drain_done,
   output logic [$clog2(CRED_MAX+1)-1:0] cred_cnt,
   output logic                          cred_err
);

   localparam int unsigned SRC_W = $clog2(NUM_REQ);
   localparam int unsigned CNT_W = $clog2(CRED_MAX + 1);
   localparam logic [CNT_W-1:0] CRED_FULL = CNT_W'(CRED_MAX);

   sched_state_e      r_state, w_state_nxt;
   logic [SRC_W-1:0]  r_rr_ptr, w_ptr_nxt, w_idx;
   logic [NUM_REQ-1:0] w_gnt;
   logic              w_en, w_grant, w_ovf;
   logic [CNT_W-1:0]  r_cred_cnt, w_cred_nxt;
   logic              r_cred_err, r_drain_done;
   logic              r_msh_valid, r_msh_wr;
   logic [ADDR_W-1:0] r_msh_addr;
   logic [SRC_W-1:0]  r_msh_src;
   logic [ADDR_W-1:0] w_addr [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign w_addr[g] = req_addr[g*ADDR_W +: ADDR_W];
   end

   // Granting is only allowed in RUN with a credit in hand; a credit returned
   // this cycle is not usable until the next one.
   assign w_en = (r_state == ST_RUN) && (r_cred_cnt != '0) && !rst;

   mby_gmm_rr_arb #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .i_req   (req_valid),
      .i_ptr   (r_rr_ptr),
      .i_en    (w_en),
      .o_gnt_c (w_gnt),
      .o_idx_c (w_idx)
   );

   assign w_grant   = |w_gnt;
   assign w_ptr_nxt = (w_idx == SRC_W'(NUM_REQ - 1)) ? '0 : w_idx + SRC_W'(1);

   // Next state and credit accounting.
   always_comb begin
      w_state_nxt = r_state;
      w_cred_nxt  = r_cred_cnt;
      w_ovf       = 1'b0;
      case (r_state)
         ST_RUN:     if (drain_req)                 w_state_nxt = ST_DRAIN;
         ST_DRAIN:   if (r_cred_cnt == CRED_FULL)   w_state_nxt = ST_DRAINED;
         ST_DRAINED: if (!drain_req)                w_state_nxt = ST_RUN;
         default:                                   w_state_nxt = ST_RUN;
      endcase
      if (w_grant && !msh_cred_ret) begin
         w_cred_nxt = r_cred_cnt - CNT_W'(1);
      end else if (!w_grant && msh_cred_ret) begin
         if (r_cred_cnt == CRED_FULL) w_ovf      = 1'b1;
         else                         w_cred_nxt = r_cred_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_RUN;
         r_rr_ptr     <= '0;
         r_cred_cnt   <= CRED_FULL;
         r_cred_err   <= 1'b0;
         r_drain_done <= 1'b0;
         r_msh_valid  <= 1'b0;
         r_msh_wr     <= 1'b0;
         r_msh_addr   <= '0;
         r_msh_src    <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_cred_cnt   <= w_cred_nxt;
         r_drain_done <= (w_state_nxt == ST_DRAINED);
         r_msh_valid  <= w_grant;
         if (w_ovf) r_cred_err <= 1'b1;
         if (w_grant) begin
            r_rr_ptr   <= w_ptr_nxt;
            r_msh_wr   <= req_wr[w_idx];
            r_msh_addr <= w_addr[w_idx];
            r_msh_src  <= w_idx;
         end
      end
   end

   assign req_ready  = w_gnt;
   assign msh_valid  = r_msh_valid;
   assign msh_wr     = r_msh_wr;
   assign msh_addr   = r_msh_addr;
   assign msh_src    = r_msh_src;
   assign drain_done = r_drain_done;
   assign cred_cnt   = r_cred_cnt;
   assign cred_err   = r_cred_err;

endmodule
